// File: rtl/r4_ifft_seq.sv
// r4_ifft_seq: sequential radix-4 inverse butterfly.
// Accepts one block of four complex samples through a valid/ready handshake,
// then streams y0..y3 one per output handshake with full backpressure.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid && ready are both high. A valid source holds its payload stable until
// that transfer. in_ready and out_last are decoded from registered state only,
// so there is no combinational path from in_valid or out_ready to any output.
module r4_ifft_seq #(
  parameter int W     = 4,
  parameter int SCALE = 0
) (
`ifdef USE_POWER_PINS
  inout  wire          vccd1,
  inout  wire          vssd1,
`endif
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] ar0,
  input  logic [W-1:0] ai0,
  input  logic [W-1:0] ar1,
  input  logic [W-1:0] ai1,
  input  logic [W-1:0] ar2,
  input  logic [W-1:0] ai2,
  input  logic [W-1:0] ar3,
  input  logic [W-1:0] ai3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic [1:0]   out_idx,
  output logic         out_last,
  output logic         busy
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t       state, state_n;
  logic [W-1:0] smp_r [4];
  logic [W-1:0] smp_i [4];

  logic         cap;
  logic         out_valid_n;
  logic [1:0]   out_idx_n;
  logic [W-1:0] out_re_n, out_im_n;

  // Butterfly operand mux and output index being computed
  logic [W-1:0] src_r [4];
  logic [W-1:0] src_i [4];
  logic [1:0]   sel_k;
  logic [W+1:0] xr [4];
  logic [W+1:0] xi [4];
  logic [W+1:0] sum_re, sum_im;
  logic [W-1:0] y_re, y_im;

  // In IDLE the butterfly sees the incoming block (for y0); in SEND it sees the
  // captured samples and computes the next index.
  always_comb begin
    src_r[0] = ar0; src_i[0] = ai0;
    src_r[1] = ar1; src_i[1] = ai1;
    src_r[2] = ar2; src_i[2] = ai2;
    src_r[3] = ar3; src_i[3] = ai3;
    sel_k    = 2'd0;
    if (state == SEND) begin
      for (int k = 0; k < 4; k++) begin
        src_r[k] = smp_r[k];
        src_i[k] = smp_i[k];
      end
      sel_k = out_idx + 2'd1;
    end
  end

  // Sign-extend to W+2 bits and form the selected inverse-DFT output
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      xr[k] = {{2{src_r[k][W-1]}}, src_r[k]};
      xi[k] = {{2{src_i[k][W-1]}}, src_i[k]};
    end
    sum_re = '0;
    sum_im = '0;
    case (sel_k)
      2'd0: begin
        sum_re = xr[0] + xr[1] + xr[2] + xr[3];
        sum_im = xi[0] + xi[1] + xi[2] + xi[3];
      end
      2'd1: begin
        sum_re = xr[0] - xi[1] - xr[2] + xi[3];
        sum_im = xi[0] + xr[1] - xi[2] - xr[3];
      end
      2'd2: begin
        sum_re = xr[0] - xr[1] + xr[2] - xr[3];
        sum_im = xi[0] - xi[1] + xi[2] - xi[3];
      end
      default: begin
        sum_re = xr[0] + xi[1] - xr[2] - xi[3];
        sum_im = xi[0] - xr[1] - xi[2] + xr[3];
      end
    endcase
    y_re = (SCALE != 0) ? sum_re[W+1:2] : sum_re[W-1:0];
    y_im = (SCALE != 0) ? sum_im[W+1:2] : sum_im[W-1:0];
  end

  // Next-state and next-output decode; everything holds unless a handshake fires
  always_comb begin
    state_n     = state;
    cap         = 1'b0;
    out_valid_n = out_valid;
    out_idx_n   = out_idx;
    out_re_n    = out_re;
    out_im_n    = out_im;
    case (state)
      IDLE: begin
        if (in_valid) begin
          cap         = 1'b1;
          out_re_n    = y_re;
          out_im_n    = y_im;
          out_idx_n   = 2'd0;
          out_valid_n = 1'b1;
          state_n     = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (out_idx == 2'd3) begin
            out_valid_n = 1'b0;
            out_idx_n   = 2'd0;
            state_n     = IDLE;
          end else begin
            out_idx_n = out_idx + 2'd1;
            out_re_n  = y_re;
            out_im_n  = y_im;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, output and sample registers; reset discards any block in flight
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= 2'd0;
      out_re    <= '0;
      out_im    <= '0;
      for (int k = 0; k < 4; k++) begin
        smp_r[k] <= '0;
        smp_i[k] <= '0;
      end
    end else begin
      state     <= state_n;
      out_valid <= out_valid_n;
      out_idx   <= out_idx_n;
      out_re    <= out_re_n;
      out_im    <= out_im_n;
      if (cap) begin
        smp_r[0] <= ar0; smp_i[0] <= ai0;
        smp_r[1] <= ar1; smp_i[1] <= ai1;
        smp_r[2] <= ar2; smp_i[2] <= ai2;
        smp_r[3] <= ar3; smp_i[3] <= ai3;
      end
    end
  end

  assign in_ready = (state == IDLE) && !wb_rst_i;
  assign busy     = (state == SEND);
  assign out_last = out_valid && (out_idx == 2'd3);

endmodule

// File: tb/tb_r4_ifft_seq.sv
// Bench for r4_ifft_seq: two instances (SCALE=0 and SCALE=1) share all inputs.
// Expected outputs come from a complex inverse-DFT model (rotation by j^(n*k)).
module tb_r4_ifft_seq;
  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [8*W-1:0]   blk = '0;
  logic [W-1:0]     ar0, ai0, ar1, ai1, ar2, ai2, ar3, ai3;
  assign ar0 = blk[0*W +: W]; assign ai0 = blk[1*W +: W];
  assign ar1 = blk[2*W +: W]; assign ai1 = blk[3*W +: W];
  assign ar2 = blk[4*W +: W]; assign ai2 = blk[5*W +: W];
  assign ar3 = blk[6*W +: W]; assign ai3 = blk[7*W +: W];

  logic         in_ready0, o_valid0, o_last0, busy0;
  logic [W-1:0] o_re0, o_im0;
  logic [1:0]   o_idx0;
  logic         in_ready1, o_valid1, o_last1, busy1;
  logic [W-1:0] o_re1, o_im1;
  logic [1:0]   o_idx1;

  r4_ifft_seq #(.W(W), .SCALE(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .ar0(ar0), .ai0(ai0), .ar1(ar1), .ai1(ai1), .ar2(ar2), .ai2(ai2), .ar3(ar3), .ai3(ai3),
    .out_valid(o_valid0), .out_ready(out_ready), .out_re(o_re0), .out_im(o_im0),
    .out_idx(o_idx0), .out_last(o_last0), .busy(busy0));

  r4_ifft_seq #(.W(W), .SCALE(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .ar0(ar0), .ai0(ai0), .ar1(ar1), .ai1(ai1), .ar2(ar2), .ai2(ai2), .ar3(ar3), .ai3(ai3),
    .out_valid(o_valid1), .out_ready(out_ready), .out_re(o_re1), .out_im(o_im1),
    .out_idx(o_idx1), .out_last(o_last1), .busy(busy1));

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [8*W-1:0] mk(input int r0, i0, r1, i1, r2, i2, r3, i3);
    logic [8*W-1:0] b;
    b[0*W +: W] = r0[W-1:0]; b[1*W +: W] = i0[W-1:0];
    b[2*W +: W] = r1[W-1:0]; b[3*W +: W] = i1[W-1:0];
    b[4*W +: W] = r2[W-1:0]; b[5*W +: W] = i2[W-1:0];
    b[6*W +: W] = r3[W-1:0]; b[7*W +: W] = i3[W-1:0];
    return b;
  endfunction

  // y[n] = sum_k a_k * j^(n*k); returns {idx, re, im} after wrap or divide-by-4
  function automatic logic [2*W+1:0] model_y(input logic [8*W-1:0] b, input int n, input int scale);
    int sr, si, r, i, t, vr, vi;
    logic [W-1:0] c;
    logic [1:0]   nn;
    sr = 0; si = 0;
    for (int k = 0; k < 4; k++) begin
      c = b[(2*k)*W +: W];   r = int'($signed(c));
      c = b[(2*k+1)*W +: W]; i = int'($signed(c));
      for (int m = 0; m < (n*k) % 4; m++) begin
        t = r; r = -i; i = t;
      end
      sr += r; si += i;
    end
    vr = (scale != 0) ? (sr >>> 2) : sr;
    vi = (scale != 0) ? (si >>> 2) : si;
    nn = n[1:0];
    return {nn, vr[W-1:0], vi[W-1:0]};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [2*W+1:0] exp_q0[$];
  logic [2*W+1:0] exp_q1[$];
  int             m_rem = 0;          // outputs still owed by the current block
  bit             mon_en = 1'b0;
  bit             prev_stall = 1'b0;
  logic [2*W+1:0] held0, held1;
  logic [2*W+1:0] e0, e1;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid0", o_valid0, m_rem != 0);
      chk("valid1", o_valid1, m_rem != 0);
      chk("busy0", busy0, m_rem != 0);
      chk("last0", o_last0, m_rem == 1);
      chk("last1", o_last1, m_rem == 1);
      chk("in_ready0", in_ready0, (m_rem == 0) && !rst);
      chk("in_ready1", in_ready1, (m_rem == 0) && !rst);
      if (prev_stall) begin
        chk("stall_hold0", {o_idx0, o_re0, o_im0}, held0);
        chk("stall_hold1", {o_idx1, o_re1, o_im1}, held1);
      end
      prev_stall = (m_rem > 0) && !out_ready && !rst;
      held0 = {o_idx0, o_re0, o_im0};
      held1 = {o_idx1, o_re1, o_im1};
      if (rst) begin
        exp_q0.delete();
        exp_q1.delete();
        m_rem = 0;
      end else if (m_rem > 0 && out_ready) begin
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e0 = exp_q0.pop_front();
          e1 = exp_q1.pop_front();
          chk("y_s0", {o_idx0, o_re0, o_im0}, e0);
          chk("y_s1", {o_idx1, o_re1, o_im1}, e1);
        end
        m_rem--;
      end else if (m_rem == 0 && in_valid) begin
        for (int n = 0; n < 4; n++) begin
          exp_q0.push_back(model_y(blk, n, 0));
          exp_q1.push_back(model_y(blk, n, 1));
        end
        m_rem = 4;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the accepting edge; y0 is then on the outputs
  task automatic send_block(input logic [8*W-1:0] b, input bit hold);
    int n;
    blk = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready0 && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready0) chk("send_timeout", 0, 1);
    else tick();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((o_valid0 || o_valid1) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_timeout", o_valid0 || o_valid1, 0);
  endtask

  // ---------------- directed sequence ----------------
  logic [8*W-1:0] imp_blk, shift_blk, wrap_blk, bp_blk, rs_blk;
  logic [W-1:0]   sh_re [4];
  logic [W-1:0]   sh_im [4];
  logic [2*W+1:0] bp_y1;
  int             acc_cyc, prev_acc;

  initial begin
    imp_blk   = mk(1, 0, 0, 0, 0, 0, 0, 0);
    shift_blk = mk(0, 0, 1, 0, 0, 0, 0, 0);
    wrap_blk  = mk(7, 0, 7, 0, 7, 0, 7, 0);
    bp_blk    = mk(3, -2, 5, 1, -4, 6, 2, -7);
    rs_blk    = mk(-8, 7, 4, -3, 1, 1, -5, 2);
    sh_re = '{4'h1, 4'h0, 4'hF, 4'h0};
    sh_im = '{4'h0, 4'h1, 4'h0, 4'hF};

    // model pins against hand-computed values
    chk("pin_imp_y3",   model_y(imp_blk, 3, 0),   {2'd3, 4'h1, 4'h0});
    chk("pin_shift_y1", model_y(shift_blk, 1, 0), {2'd1, 4'h0, 4'h1});
    chk("pin_shift_y2", model_y(shift_blk, 2, 0), {2'd2, 4'hF, 4'h0});
    chk("pin_shift_y3", model_y(shift_blk, 3, 0), {2'd3, 4'h0, 4'hF});
    chk("pin_wrap_s0",  model_y(wrap_blk, 0, 0),  {2'd0, 4'hC, 4'h0});
    chk("pin_wrap_s1",  model_y(wrap_blk, 0, 1),  {2'd0, 4'h7, 4'h0});
    chk("pin_wrap_y1",  model_y(wrap_blk, 1, 0),  {2'd1, 4'h0, 4'h0});

    // reset state
    tick();
    mon_en = 1'b1;
    chk("rst_in_ready", in_ready0, 0);
    chk("rst_valid", o_valid0, 0);
    chk("rst_re_im", {o_re0, o_im0, o_re1, o_im1}, 0);
    chk("rst_idx", o_idx0, 0);
    chk("rst_busy", busy0, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready0, 1);

    // impulse: all outputs (1,0)
    out_ready = 1'b1;
    send_block(imp_blk, 1'b0);
    for (int n = 0; n < 4; n++) begin
      chk("imp_valid", o_valid0, 1);
      chk("imp_idx", o_idx0, n);
      chk("imp_last", o_last0, n == 3);
      chk("imp_val", {o_re0, o_im0}, {4'h1, 4'h0});
      chk("imp_in_ready", in_ready0, 0);
      tick();
    end
    chk("imp_done_in_ready", in_ready0, 1);
    chk("imp_done_valid", o_valid0, 0);

    // shifted impulse
    send_block(shift_blk, 1'b0);
    for (int n = 0; n < 4; n++) begin
      chk("shift_val", {o_idx0, o_re0, o_im0}, {n[1:0], sh_re[n], sh_im[n]});
      tick();
    end

    // wrap versus scale
    send_block(wrap_blk, 1'b0);
    chk("wrap_s0_y0", {o_re0, o_im0}, {4'hC, 4'h0});
    chk("wrap_s1_y0", {o_re1, o_im1}, {4'h7, 4'h0});
    drain();

    // backpressure at idx 1 with a stray in_valid during SEND
    out_ready = 1'b0;
    send_block(bp_blk, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1;
    blk = rs_blk;
    bp_y1 = model_y(bp_blk, 1, 0);
    for (int n = 0; n < 3; n++) begin
      chk("bp_hold", {o_idx0, o_re0, o_im0}, bp_y1);
      chk("bp_in_ready", in_ready0, 0);
      tick();
    end
    in_valid = 1'b0;
    drain();

    // reset mid-block after idx 1 is accepted
    send_block(rs_blk, 1'b0);
    tick();
    tick();
    chk("rs_pre_idx", o_idx0, 2);
    rst = 1'b1;
    tick();
    chk("rs_valid", o_valid0, 0);
    chk("rs_in_ready_during", in_ready0, 0);
    rst = 1'b0;
    #1;
    chk("rs_in_ready_after", in_ready0, 1);
    send_block(imp_blk, 1'b0);
    chk("rs_restart", {o_idx0, o_re0, o_im0}, {2'd0, 4'h1, 4'h0});
    drain();

    // back-to-back: in_valid held high, new data each block
    out_ready = 1'b1;
    prev_acc = 0;
    for (int b = 0; b < 8; b++) begin
      send_block(mk($urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15),
                    $urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15)), 1'b1);
      acc_cyc = cyc;
      if (b > 0) chk("b2b_spacing", acc_cyc - prev_acc, 5);
      prev_acc = acc_cyc;
    end
    in_valid = 1'b0;
    drain();
    tick();

    chk("sb_empty0", exp_q0.size(), 0);
    chk("sb_empty1", exp_q1.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
